// File: rtl/switch_allocator.sv
// Per-output crossbar arbiter for one mesh node: five inputs, five outputs.
// Priority order is starved, then QoS, then the rest, with round-robin inside each class.
module switch_allocator #(
   parameter int STARVE_LIMIT = 15,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  in_valid,
   input  logic [24:0] in_req,
   input  logic [4:0]  in_qos,
   input  logic [4:0]  out_ready,
   output logic [4:0]  in_grant,
   output logic [4:0]  out_valid,
   output logic [14:0] out_sel,
   output logic        err_onehot
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [2:0]       rr_ptr_q   [5];
   logic [2:0]       rr_ptr_d   [5];
   logic [CNT_W-1:0] wait_cnt_q [5];
   logic [CNT_W-1:0] wait_cnt_d [5];
   logic             err_onehot_q;
   logic             err_onehot_d;

   logic [4:0] req_ok;
   logic [4:0] malformed;
   logic [4:0] starved;

   always_comb begin : decode
      logic [4:0] slice;
      logic       well_formed;
      req_ok    = '0;
      malformed = '0;
      starved   = '0;
      for (int i = 0; i < 5; i++) begin
         slice        = in_req[5*i +: 5];
         well_formed  = (slice != 5'd0) && ((slice & (slice - 5'd1)) == 5'd0);
         req_ok[i]    = in_valid[i] & well_formed;
         malformed[i] = in_valid[i] & ~well_formed;
         starved[i]   = (wait_cnt_q[i] == LIMIT);
      end
   end

   always_comb begin : arbitrate
      logic [4:0] cand;
      logic [4:0] pool;
      logic       found;
      logic [2:0] win;
      int         idx;
      in_grant  = '0;
      out_valid = '0;
      out_sel   = '0;
      cand      = '0;
      pool      = '0;
      found     = 1'b0;
      win       = '0;
      idx       = 0;
      for (int o = 0; o < 5; o++) begin
         rr_ptr_d[o] = rr_ptr_q[o];
         for (int i = 0; i < 5; i++) begin
            cand[i] = req_ok[i] & in_req[5*i + o];
         end
         if ((cand & starved) != 5'd0)     pool = cand & starved;
         else if ((cand & in_qos) != 5'd0) pool = cand & in_qos;
         else                              pool = cand;
         found = 1'b0;
         win   = '0;
         for (int k = 0; k < 5; k++) begin
            idx = int'(rr_ptr_q[o]) + k;
            if (idx > 4) idx = idx - 5;
            if (!found && pool[idx]) begin
               found = 1'b1;
               win   = 3'(idx);
            end
         end
         // rst gating makes a mid-cycle reset kill the transfer immediately
         if (found && out_ready[o] && !rst) begin
            out_valid[o]      = 1'b1;
            out_sel[3*o +: 3] = win;
            in_grant[win]     = 1'b1;
            rr_ptr_d[o]       = (win == 3'd4) ? 3'd0 : win + 3'd1;
         end
      end
   end

   always_comb begin : counters
      for (int i = 0; i < 5; i++) begin
         if (in_grant[i] || !req_ok[i])   wait_cnt_d[i] = '0;
         else if (wait_cnt_q[i] == LIMIT) wait_cnt_d[i] = wait_cnt_q[i];
         else                             wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
      end
      err_onehot_d = err_onehot_q | (|malformed);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 5; i++) begin
            rr_ptr_q[i]   <= '0;
            wait_cnt_q[i] <= '0;
         end
         err_onehot_q <= 1'b0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            rr_ptr_q[i]   <= rr_ptr_d[i];
            wait_cnt_q[i] <= wait_cnt_d[i];
         end
         err_onehot_q <= err_onehot_d;
      end
   end

   assign err_onehot = err_onehot_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus randomized flit traffic,
// all checked against a behavioural priority/round-robin model.
module tb_switch_allocator;

   localparam int SL = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  in_valid;
   logic [24:0] in_req;
   logic [4:0]  in_qos;
   logic [4:0]  out_ready;
   logic [4:0]  in_grant;
   logic [4:0]  out_valid;
   logic [14:0] out_sel;
   logic        err_onehot;

   switch_allocator #(.STARVE_LIMIT(SL), .CNT_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_req     (in_req),
      .in_qos     (in_qos),
      .out_ready  (out_ready),
      .in_grant   (in_grant),
      .out_valid  (out_valid),
      .out_sel    (out_sel),
      .err_onehot (err_onehot)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          m_rr   [5];
   int          m_wait [5];
   bit          m_err;
   logic [4:0]  eg;
   logic [4:0]  ev;
   logic [14:0] es;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic bit single_bit(input logic [4:0] s);
      return $countones(s) == 1;
   endfunction

   // Rank = 2 starved, 1 qos, 0 plain; ties go to smallest distance from rr pointer.
   task automatic model_eval();
      int best, bp, bd, p, d;
      logic [4:0] s;
      eg = '0; ev = '0; es = '0;
      if (rst) return;
      for (int o = 0; o < 5; o++) begin
         best = -1; bp = -1; bd = 99;
         for (int i = 0; i < 5; i++) begin
            s = in_req[5*i +: 5];
            if (in_valid[i] && single_bit(s) && s[o]) begin
               p = (m_wait[i] == SL) ? 2 : (in_qos[i] ? 1 : 0);
               d = (i - m_rr[o] + 5) % 5;
               if (p > bp || (p == bp && d < bd)) begin
                  best = i; bp = p; bd = d;
               end
            end
         end
         if (best >= 0 && out_ready[o]) begin
            ev[o] = 1'b1;
            es[3*o +: 3] = 3'(best);
            eg[best] = 1'b1;
         end
      end
   endtask

   task automatic model_step();
      logic [4:0] s;
      for (int o = 0; o < 5; o++)
         if (ev[o]) m_rr[o] = (int'(es[3*o +: 3]) + 1) % 5;
      for (int i = 0; i < 5; i++) begin
         s = in_req[5*i +: 5];
         if (in_valid[i] && !single_bit(s)) m_err = 1'b1;
         if (eg[i] || !in_valid[i] || !single_bit(s)) m_wait[i] = 0;
         else if (m_wait[i] < SL) m_wait[i] = m_wait[i] + 1;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_rr[i] = 0; m_wait[i] = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic at_neg();
      @(negedge clk);
      model_eval();
      chk("in_grant", 32'(in_grant), 32'(eg));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_sel", 32'(out_sel), 32'(es));
      chk("err_onehot", 32'(err_onehot), 32'(m_err));
   endtask

   task automatic at_pos();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cycle();
      at_neg();
      at_pos();
   endtask

   task automatic drive(input logic [4:0] v, input logic [24:0] r,
                        input logic [4:0] q, input logic [4:0] rdy);
      in_valid = v; in_req = r; in_qos = q; out_ready = rdy;
   endtask

   // Called shortly after a rising edge; asserts rst mid-cycle for one clock.
   task automatic reset_pulse();
      #2 rst = 1'b1;
      #1;
      chk("rst_grant", 32'(in_grant), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sel", 32'(out_sel), 32'd0);
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   logic [4:0]  f_v;
   logic [24:0] f_r;
   logic [4:0]  f_q;

   task automatic new_flit(input int i);
      f_v[i] = ($urandom % 4) != 0;
      f_r[5*i +: 5] = (($urandom % 25) == 0) ? 5'($urandom) : 5'(1 << ($urandom % 5));
      f_q[i] = ($urandom % 3) == 0;
   endtask

   initial begin
      rst = 1'b1;
      drive('0, '0, '0, '0);
      model_reset();
      #1;
      chk("reset_grant", 32'(in_grant), 32'd0);
      chk("reset_err", 32'(err_onehot), 32'd0);
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b0;

      // input 0 to E
      drive(5'b00001, 25'b01000, 5'b0, 5'h1F);
      at_neg();
      chk("t1_grant", 32'(in_grant), 32'b00001);
      chk("t1_valid", 32'(out_valid), 32'b01000);
      chk("t1_sel", 32'(out_sel[11:9]), 32'd0);
      at_pos();

      // inputs 1,2,4 all to B
      drive(5'b10110, {5'b10000, 5'b0, 5'b10000, 5'b10000, 5'b0}, 5'b0, 5'h1F);
      for (int c = 0; c < 4; c++) begin
         at_neg();
         chk("t2_grant", 32'(in_grant), (c == 0 || c == 3) ? 32'b00010 : (c == 1 ? 32'b00100 : 32'b10000));
         chk("t2_sel", 32'(out_sel[14:12]), (c == 0 || c == 3) ? 32'd1 : (c == 1 ? 32'd2 : 32'd4));
         at_pos();
      end
      reset_pulse();
      for (int c = 0; c < 3; c++) begin
         at_neg();
         chk("t6_grant", 32'(in_grant), c == 0 ? 32'b00010 : (c == 1 ? 32'b00100 : 32'b10000));
         at_pos();
      end

      // starvation: input 0 qos0 vs input 3 qos1, both to N
      drive('0, '0, '0, '0);
      reset_pulse();
      drive(5'b01001, {5'b0, 5'b00001, 5'b0, 5'b0, 5'b00001}, 5'b01000, 5'h1F);
      for (int c = 0; c < 5; c++) begin
         at_neg();
         chk("t3_grant", 32'(in_grant), c == 3 ? 32'b00001 : 32'b01000);
         at_pos();
      end

      // back-pressure on S
      drive('0, '0, '0, '0);
      reset_pulse();
      drive(5'b00100, {5'b0, 5'b0, 5'b00100, 5'b0, 5'b0}, 5'b0, 5'b11011);
      for (int c = 0; c < 5; c++) begin
         at_neg();
         chk("t4_grant", 32'(in_grant), 32'd0);
         chk("t4_valid", 32'(out_valid), 32'd0);
         at_pos();
      end
      out_ready = 5'h1F;
      at_neg();
      chk("t4_ready_grant", 32'(in_grant), 32'b00100);
      chk("t4_ready_sel", 32'(out_sel), 32'(15'd2 << 6));
      at_pos();

      // malformed request, sticky error
      drive(5'b00100, {5'b0, 5'b0, 5'b00011, 5'b0, 5'b0}, 5'b0, 5'h1F);
      at_neg();
      chk("t5_grant", 32'(in_grant), 32'd0);
      chk("t5_err_before", 32'(err_onehot), 32'd0);
      at_pos();
      drive('0, '0, '0, 5'h1F);
      at_neg();
      chk("t5_err_sticky", 32'(err_onehot), 32'd1);
      at_pos();
      reset_pulse();
      at_neg();
      chk("t5_err_cleared", 32'(err_onehot), 32'd0);
      at_pos();

      // random flit traffic: a flit stays at its input until granted
      f_v = '0; f_r = '0; f_q = '0;
      for (int c = 0; c < 800; c++) begin
         drive(f_v, f_r, f_q, 5'($urandom) | 5'($urandom));
         if (c % 150 == 149) reset_pulse();
         at_neg();
         at_pos();
         for (int i = 0; i < 5; i++)
            if (eg[i] || !f_v[i] || ($urandom % 10) == 0) new_flit(i);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
